// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control codes, funct encodings and FSM state for alu_control_mc.
package alu_ctrl_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [3:0] CTRL_AND = 4'd0;
    localparam logic [3:0] CTRL_OR  = 4'd1;
    localparam logic [3:0] CTRL_ADD = 4'd2;
    localparam logic [3:0] CTRL_SLL = 4'd3;
    localparam logic [3:0] CTRL_SRL = 4'd4;
    localparam logic [3:0] CTRL_SUB = 4'd6;
    localparam logic [3:0] CTRL_SLT = 4'd7;
    localparam logic [3:0] CTRL_MUL = 4'd8;

    localparam logic [9:0] FUNC_ADD = 10'b0000000_000;
    localparam logic [9:0] FUNC_SUB = 10'b0100000_000;
    localparam logic [9:0] FUNC_AND = 10'b0000000_111;
    localparam logic [9:0] FUNC_OR  = 10'b0000000_110;
    localparam logic [9:0] FUNC_SLT = 10'b0000000_010;
    localparam logic [9:0] FUNC_SLL = 10'b0000000_001;
    localparam logic [9:0] FUNC_SRL = 10'b0000000_101;
    localparam logic [9:0] FUNC_MUL = 10'b0000001_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] decode_rtype(input logic [9:0] funct);
        logic [3:0] code;
        code = CTRL_AND;
        unique case (1'b1)
            (funct == FUNC_ADD): code = CTRL_ADD;
            (funct == FUNC_SUB): code = CTRL_SUB;
            (funct == FUNC_AND): code = CTRL_AND;
            (funct == FUNC_OR):  code = CTRL_OR;
            (funct == FUNC_SLT): code = CTRL_SLT;
            (funct == FUNC_SLL): code = CTRL_SLL;
            (funct == FUNC_SRL): code = CTRL_SRL;
            (funct == FUNC_MUL): code = CTRL_MUL;
            default:             code = CTRL_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_control_mc_mul_iter_sa.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step.
module mul_iter_sa
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand_in,
    input  logic [DATA_W-1:0] mplier_in,
    output logic [DATA_W-1:0] acc,
    output logic              zero_mplier,
    output logic              last_iter
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;

    // High when the step taken this cycle leaves the multiplier empty.
    assign zero_mplier = ~|mplier[DATA_W-1:1];
    assign last_iter   = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_control_mc.sv
// EX-stage ALU control decoder with a stalling iterative RV32M MUL.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [1:0]        alu_op,
    input  logic [6:0]        func7,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              is_mul,
    output logic [DATA_W-1:0] mul_result,
    output logic              mul_valid,
    output logic              stall
);

    localparam int  CNT_W = $clog2(DATA_W + 1);
    localparam bit  EE    = (EARLY_EXIT != 0);

    state_t     state;
    logic [9:0] funct;
    logic [3:0] ctrl;
    logic       start;
    logic       step;
    logic       finish;
    logic       zero_mplier;
    logic       last_iter;

    assign funct = {func7, func3};

    always_comb begin
        ctrl = CTRL_AND;
        unique case (1'b1)
            (alu_op == ALU_OP_ADD):   ctrl = CTRL_ADD;
            (alu_op == ALU_OP_SUB):   ctrl = CTRL_SUB;
            (alu_op == ALU_OP_RTYPE): ctrl = decode_rtype(funct);
            default:                  ctrl = CTRL_AND;
        endcase
    end

    assign alu_control = CTRL_W'(ctrl);
    assign is_mul      = (alu_op == ALU_OP_RTYPE) && (funct == FUNC_MUL);

    assign start  = (state == ST_IDLE) && valid_in && is_mul;
    assign step   = (state == ST_BUSY);
    assign finish = last_iter || (EE && zero_mplier);
    assign stall  = rst_n && (start || step);

    mul_iter_sa #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mul (
        .clk         (clk),
        .clear       (!rst_n),
        .start       (start),
        .step        (step),
        .mcand_in    (op_a),
        .mplier_in   (op_b),
        .acc         (mul_result),
        .zero_mplier (zero_mplier),
        .last_iter   (last_iter)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mul_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    mul_valid <= 1'b0;
                    if (start) begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        state     <= ST_DONE;
                        mul_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // The finishing MUL is still presented here; never restart.
                    state     <= ST_IDLE;
                    mul_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mul_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc, with and without early exit.
module tb_alu_control_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid0;
    logic        valid1;
    logic [1:0]  alu_op;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [3:0]  ctrl0, ctrl1;
    logic        is_mul0, is_mul1;
    logic [31:0] res0, res1;
    logic        mv0, mv1;
    logic        stall0, stall1;

    int tests = 0;
    int fails = 0;

    localparam logic [9:0] TBL_F [8] = '{
        10'b0000000_000, 10'b0100000_000, 10'b0000000_111, 10'b0000000_110,
        10'b0000000_010, 10'b0000000_001, 10'b0000000_101, 10'b0000001_000
    };
    localparam logic [3:0] TBL_C [8] = '{
        4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd3, 4'd4, 4'd8
    };

    always #5 clk = ~clk;

    alu_control_mc #(.DATA_W(32), .CTRL_W(4), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid0),
        .alu_op(alu_op), .func7(func7), .func3(func3),
        .op_a(op_a), .op_b(op_b),
        .alu_control(ctrl0), .is_mul(is_mul0), .mul_result(res0),
        .mul_valid(mv0), .stall(stall0)
    );

    alu_control_mc #(.DATA_W(32), .CTRL_W(4), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid1),
        .alu_op(alu_op), .func7(func7), .func3(func3),
        .op_a(op_a), .op_b(op_b),
        .alu_control(ctrl1), .is_mul(is_mul1), .mul_result(res1),
        .mul_valid(mv1), .stall(stall1)
    );

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op,
                                            input logic [9:0] f);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd0;
        for (int i = 0; i < 8; i++)
            if (f == TBL_F[i]) return TBL_C[i];
        return 4'd0;
    endfunction

    // BUSY cycles: full width, or the multiplier's bit length (min 1).
    function automatic int busy_cycles(input bit ee, input logic [31:0] b);
        int n;
        logic [31:0] t;
        if (!ee) return 32;
        n = 0;
        t = b;
        while (t != 0) begin
            t = t >> 1;
            n++;
        end
        return (n == 0) ? 1 : n;
    endfunction

    task automatic set_funct(input logic [1:0] op, input logic [9:0] f);
        alu_op = op;
        {func7, func3} = f;
    endtask

    task automatic run_mul(input bit sel, input logic [31:0] a,
                           input logic [31:0] b, input bit hold,
                           input string name);
        logic [63:0] p;
        logic [31:0] exp;
        int busy;
        p = 64'(a) * 64'(b);
        exp = p[31:0];
        busy = busy_cycles(sel, b);
        @(negedge clk);
        set_funct(2'b10, 10'b0000001_000);
        op_a = a;
        op_b = b;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        #1;
        tests++;
        if ((sel ? stall1 : stall0) !== 1'b1 || (sel ? is_mul1 : is_mul0) !== 1'b1
            || (sel ? ctrl1 : ctrl0) !== 4'd8) begin
            fails++;
            $display("FAIL %s start: stall=%b is_mul=%b ctrl=%0d want 1 1 8",
                     name, sel ? stall1 : stall0, sel ? is_mul1 : is_mul0,
                     sel ? ctrl1 : ctrl0);
        end
        for (int k = 1; k <= busy; k++) begin
            @(negedge clk);
            op_a = $urandom;
            op_b = $urandom;
            #1;
            tests++;
            if ((sel ? stall1 : stall0) !== 1'b1 || (sel ? mv1 : mv0) !== 1'b0) begin
                fails++;
                $display("FAIL %s busy cycle %0d: stall=%b mul_valid=%b want 1 0",
                         name, k, sel ? stall1 : stall0, sel ? mv1 : mv0);
            end
        end
        @(negedge clk);
        op_a = $urandom;
        op_b = $urandom;
        if (sel) valid1 = hold; else valid0 = hold;
        #1;
        tests++;
        if ((sel ? mv1 : mv0) !== 1'b1 || (sel ? res1 : res0) !== exp
            || (sel ? stall1 : stall0) !== 1'b0) begin
            fails++;
            $display("FAIL %s done: mul_valid=%b result=%h stall=%b want 1 %h 0",
                     name, sel ? mv1 : mv0, sel ? res1 : res0,
                     sel ? stall1 : stall0, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_funct(2'b10, 10'b0000001_000);
        valid0 = 1'b1;
        valid1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (stall0 !== 1'b0 || mv0 !== 1'b0 || res0 !== 32'd0 || stall1 !== 1'b0
            || mv1 !== 1'b0 || res1 !== 32'd0) begin
            fails++;
            $display("FAIL reset outputs: stall=%b/%b mv=%b/%b res=%h/%h want zeros",
                     stall0, stall1, mv0, mv1, res0, res1);
        end
        tests++;
        if (ctrl0 !== 4'd8 || is_mul0 !== 1'b1) begin
            fails++;
            $display("FAIL reset decode: ctrl=%0d is_mul=%b want 8 1", ctrl0, is_mul0);
        end
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [9:0] f;
        logic [1:0] op;
        @(negedge clk);
        valid0 = 1'b1;
        set_funct(2'b10, 10'b0100000_000);
        #1;
        tests++;
        if (ctrl0 !== 4'd6 || is_mul0 !== 1'b0 || stall0 !== 1'b0) begin
            fails++;
            $display("FAIL decode sub: ctrl=%0d is_mul=%b stall=%b want 6 0 0",
                     ctrl0, is_mul0, stall0);
        end
        set_funct(2'b10, 10'b0000011_111);
        #1;
        tests++;
        if (ctrl0 !== 4'd0 || stall0 !== 1'b0) begin
            fails++;
            $display("FAIL decode unknown: ctrl=%0d stall=%b want 0 0", ctrl0, stall0);
        end
        set_funct(2'b00, 10'b0000001_000);
        #1;
        tests++;
        if (ctrl0 !== 4'd2 || is_mul0 !== 1'b0 || stall0 !== 1'b0) begin
            fails++;
            $display("FAIL decode add-mul funct: ctrl=%0d is_mul=%b stall=%b want 2 0 0",
                     ctrl0, is_mul0, stall0);
        end
        @(negedge clk);
        valid0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 1) == 1) ? TBL_F[$urandom_range(0, 7)]
                                            : 10'($urandom);
            set_funct(op, f);
            #1;
            tests++;
            if (ctrl0 !== ref_ctrl(op, f) || ctrl1 !== ref_ctrl(op, f)
                || is_mul0 !== (op == 2'b10 && f == 10'b0000001_000)
                || stall0 !== 1'b0) begin
                fails++;
                $display("FAIL decode rand op=%0d f=%b: ctrl=%0d/%0d is_mul=%b want %0d",
                         op, f, ctrl0, ctrl1, is_mul0, ref_ctrl(op, f));
            end
            #4;
        end
    endtask

    task automatic test_mul_latency();
        run_mul(1'b0, 32'd7, 32'd6, 1'b0, "mul 7x6");
        idle_cycle();
    endtask

    task automatic test_wrap();
        run_mul(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0, "mul ffffffffx3");
        idle_cycle();
        run_mul(1'b0, 32'h8000_0000, 32'd2, 1'b0, "mul 80000000x2");
        idle_cycle();
    endtask

    task automatic test_early_exit();
        run_mul(1'b1, 32'd5, 32'd3, 1'b0, "ee 5x3");
        idle_cycle();
        run_mul(1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, "ee x0");
        idle_cycle();
        run_mul(1'b1, 32'd3, 32'h8000_0001, 1'b0, "ee full");
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_funct(2'b10, 10'b0000001_000);
        op_a = 32'h1234_5677;
        op_b = 32'hFFFF_FFFF;
        valid0 = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (stall0 !== 1'b0) begin
            fails++;
            $display("FAIL reset mid forced stall: stall=%b want 0", stall0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid0 = 1'b0;
        #1;
        tests++;
        if (stall0 !== 1'b0 || mv0 !== 1'b0 || res0 !== 32'd0) begin
            fails++;
            $display("FAIL reset mid after: stall=%b mv=%b res=%h want 0 0 0",
                     stall0, mv0, res0);
        end
        run_mul(1'b0, 32'd9, 32'd9, 1'b0, "mul 9x9 after reset");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_mul(1'b0, 32'd3, 32'd4, 1'b1, "b2b 3x4");
        run_mul(1'b0, 32'd5, 32'd5, 1'b0, "b2b 5x5");
        idle_cycle();
        run_mul(1'b1, 32'd3, 32'd4, 1'b1, "ee b2b 3x4");
        run_mul(1'b1, 32'd5, 32'd5, 1'b0, "ee b2b 5x5");
        idle_cycle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_mul(i[0], a, b, 1'b0, "random mul");
            idle_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        alu_op = 2'b00;
        func7 = 7'd0;
        func3 = 3'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        test_reset();
        test_decode();
        test_mul_latency();
        test_wrap();
        test_early_exit();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
